// File: rtl/flow_control_vld_rdy_receiver.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// flow_control_vld_rdy_receiver
//
// Receive side of a vld/rdy pipeline link. Words accepted from the upstream
// stage are stored in a small circular FIFO and presented to the downstream
// consumer over a second vld/rdy handshake. Upstream in_rdy comes straight
// from a flop, so no combinational ready path crosses stage boundaries.
//
// Optional feature macro: FLOW_CONTROL_RX_BYPASS_EN
//   When defined, a word arriving at an empty FIFO while the consumer is
//   ready and the output is enabled goes straight to out_data in the same
//   cycle. It is never written, so pointers and count stay unchanged.
//   When undefined there is no combinational in->out path and the minimum
//   latency is one cycle.
//
// Parameters:
//   DATA_W     payload width
//   DEPTH      FIFO entries; must be a power of two and at least 2
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-low reset
//   en         output enable; gates out_vld (input side keeps running)
//   flush      discard every stored entry; wins over push and pop
//   in_vld     upstream word valid
//   in_data    upstream payload
//   in_rdy     registered; receiver can take a word this cycle
//   out_vld    word available to the downstream consumer
//   out_data   head-of-FIFO payload (don't-care while out_vld is low)
//   out_rdy    downstream accepts the word
//   occupancy  number of stored entries
// ---------------------------------------------------------------------------
module flow_control_vld_rdy_receiver #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       flush,
    input  logic                       in_vld,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_rdy,
    output logic                       out_vld,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       out_rdy,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    // Storage and state
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic              in_rdy_q;

    // Handshake qualifiers
    logic not_empty;
    logic push;
    logic pop;

    assign not_empty = (count != '0);
    assign in_rdy    = in_rdy_q;
    assign occupancy = count;

    // A pop only ever takes a stored word; a bypassed word never reaches
    // the FIFO, so pop cannot fire while count is zero.
    assign pop = not_empty & en & out_rdy & ~flush;

`ifdef FLOW_CONTROL_RX_BYPASS_EN
    logic bypass;

    // Empty FIFO, consumer ready, output enabled: hand the word straight
    // through instead of storing it.
    assign bypass   = ~not_empty & en & in_vld & in_rdy_q & out_rdy & ~flush;
    assign push     = in_vld & in_rdy_q & ~flush & ~bypass;
    assign out_vld  = (en & not_empty) | bypass;
    assign out_data = bypass ? in_data : mem[rd_ptr];
`else
    assign push     = in_vld & in_rdy_q & ~flush;
    assign out_vld  = en & not_empty;
    assign out_data = mem[rd_ptr];
`endif

    // Count update. Simultaneous push and pop leave it unchanged, which is
    // what keeps in_rdy high at DEPTH-1 under sustained streaming.
    // NOTE: every signal written in always_comb gets a default first so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // Control state: pointers, count and the registered ready.
    // NOTE: sequential state is written with non-blocking assignments so
    // every flop samples values from before the edge, independent of the
    // order of statements or blocks.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_rdy_q <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_rdy_q <= 1'b1;
        end else begin
            // DEPTH is a power of two, so the natural pointer wrap is the
            // modulo-DEPTH increment.
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count    <= count_next;
            // Ready follows the post-update count: a pop from full reopens
            // the input one cycle later, and a push is never accepted into
            // a full FIFO.
            in_rdy_q <= (count_next < DEPTH_CNT);
        end
    end

    // Payload storage.
    // NOTE: the memory array has no reset; contents are only meaningful
    // between a push and its pop, and leaving it unreset lets it map onto
    // plain storage without a reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Structural invariants: the count never exceeds DEPTH and a pop
    // never happens on an empty FIFO.
    a_count_bound: assert property (
        @(posedge clk) disable iff (!rst) count <= DEPTH_CNT
    );

    a_no_pop_empty: assert property (
        @(posedge clk) disable iff (!rst) pop |-> not_empty
    );

endmodule

// File: tb/tb_flow_control_vld_rdy_receiver.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_flow_control_vld_rdy_receiver
//
// Self-checking bench for flow_control_vld_rdy_receiver (DATA_W=32,
// DEPTH=4). A table of directed vectors covers reset, fill to full,
// pop-from-full, output-enable gating, flush and mid-operation reset. A
// short hand-written sequence covers the empty-FIFO first-word path, and a
// randomized phase is compared against a queue-based reference model.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_flow_control_vld_rdy_receiver;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

`ifdef FLOW_CONTROL_RX_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              flush;
    logic              in_vld;
    logic [DATA_W-1:0] in_data;
    logic              in_rdy;
    logic              out_vld;
    logic [DATA_W-1:0] out_data;
    logic              out_rdy;
    logic [2:0]        occupancy;

    int n_checks = 0;
    int n_fail   = 0;

    flow_control_vld_rdy_receiver #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .flush     (flush),
        .in_vld    (in_vld),
        .in_data   (in_data),
        .in_rdy    (in_rdy),
        .out_vld   (out_vld),
        .out_data  (out_data),
        .out_rdy   (out_rdy),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic        flush;
        logic        in_vld;
        logic [31:0] in_data;
        logic        out_rdy;
        logic        exp_in_rdy;
        logic        exp_out_vld;
        logic [31:0] exp_data;
        logic [2:0]  exp_occ;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic e, input logic f,
                                input logic iv, input logic [31:0] id, input logic ordy,
                                input logic x_rdy, input logic x_vld,
                                input logic [31:0] x_data, input logic [2:0] x_occ);
        vec_t v;
        v.rst = r; v.en = e; v.flush = f; v.in_vld = iv; v.in_data = id;
        v.out_rdy = ordy; v.exp_in_rdy = x_rdy; v.exp_out_vld = x_vld;
        v.exp_data = x_data; v.exp_occ = x_occ;
        return v;
    endfunction

    task automatic drive(input logic r, input logic e, input logic f,
                         input logic iv, input logic [31:0] id, input logic ordy);
        rst = r; en = e; flush = f; in_vld = iv; in_data = id; out_rdy = ordy;
    endtask

    // Compare all outputs at the falling edge, then advance past the
    // next rising edge.
    task automatic sample(input string tag, input logic x_rdy, input logic x_vld,
                          input logic [31:0] x_data, input logic [2:0] x_occ);
        @(negedge clk);
        check({tag, "_in_rdy"},  32'(in_rdy),    32'(x_rdy));
        check({tag, "_out_vld"}, 32'(out_vld),   32'(x_vld));
        check({tag, "_occ"},     32'(occupancy), 32'(x_occ));
        if (x_vld) check({tag, "_data"}, out_data, x_data);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] q[$];
        logic        m_rdy;
        logic        x_byp, x_vld, x_push, x_pop;
        logic [31:0] x_data;
        logic        r_en, r_fl, r_iv, r_or;
        logic [31:0] r_d;

        // Directed vectors: rst,en,flush,in_vld,in_data,out_rdy |
        //                   exp in_rdy, out_vld, out_data, occupancy
        vecs.push_back(mk(0,0,0,0,32'h0 ,0, 0,0,32'h0 ,0)); // in reset
        vecs.push_back(mk(1,0,0,0,32'h0 ,0, 0,0,32'h0 ,0)); // rst released
        vecs.push_back(mk(1,1,0,0,32'h0 ,0, 1,0,32'h0 ,0)); // in_rdy up
        vecs.push_back(mk(1,1,0,1,32'hA1,0, 1,0,32'h0 ,0));
        vecs.push_back(mk(1,1,0,1,32'hA2,0, 1,1,32'hA1,1));
        vecs.push_back(mk(1,1,0,1,32'hA3,0, 1,1,32'hA1,2));
        vecs.push_back(mk(1,1,0,1,32'hA4,0, 1,1,32'hA1,3));
        vecs.push_back(mk(1,1,0,1,32'hA5,0, 0,1,32'hA1,4)); // full
        vecs.push_back(mk(1,1,0,1,32'hA5,0, 0,1,32'hA1,4)); // A5 held off
        vecs.push_back(mk(1,1,0,1,32'hA5,1, 0,1,32'hA1,4)); // pop A1
        vecs.push_back(mk(1,1,0,1,32'hA5,0, 1,1,32'hA2,3)); // A5 accepted
        vecs.push_back(mk(1,1,0,0,32'h0 ,1, 0,1,32'hA2,4));
        vecs.push_back(mk(1,1,0,0,32'h0 ,1, 1,1,32'hA3,3));
        vecs.push_back(mk(1,1,0,0,32'h0 ,1, 1,1,32'hA4,2));
        vecs.push_back(mk(1,1,0,0,32'h0 ,1, 1,1,32'hA5,1));
        vecs.push_back(mk(1,1,0,0,32'h0 ,0, 1,0,32'h0 ,0));
        vecs.push_back(mk(1,0,0,1,32'hB1,1, 1,0,32'h0 ,0)); // en=0 push
        vecs.push_back(mk(1,0,0,0,32'h0 ,1, 1,0,32'h0 ,1)); // output frozen
        vecs.push_back(mk(1,1,0,0,32'h0 ,0, 1,1,32'hB1,1));
        vecs.push_back(mk(1,1,0,1,32'hB2,0, 1,1,32'hB1,1));
        vecs.push_back(mk(1,1,0,1,32'hB3,0, 1,1,32'hB1,2));
        vecs.push_back(mk(1,1,1,1,32'hB0,1, 1,1,32'hB1,3)); // flush + push
        vecs.push_back(mk(1,1,0,0,32'h0 ,1, 1,0,32'h0 ,0));
        vecs.push_back(mk(1,1,0,1,32'hD0,0, 1,0,32'h0 ,0));
        vecs.push_back(mk(1,1,0,0,32'h0 ,1, 1,1,32'hD0,1)); // not B0
        vecs.push_back(mk(1,1,0,0,32'h0 ,0, 1,0,32'h0 ,0));
        vecs.push_back(mk(1,1,0,1,32'hE0,0, 1,0,32'h0 ,0));
        vecs.push_back(mk(0,1,0,0,32'h0 ,0, 1,1,32'hE0,1)); // mid-op reset
        vecs.push_back(mk(1,1,0,0,32'h0 ,0, 0,0,32'h0 ,0));
        vecs.push_back(mk(1,1,0,0,32'h0 ,0, 1,0,32'h0 ,0));
        vecs.push_back(mk(1,1,0,1,32'hF0,0, 1,0,32'h0 ,0));
        vecs.push_back(mk(1,1,0,1,32'hF1,0, 1,1,32'hF0,1));
        vecs.push_back(mk(1,1,0,1,32'hF2,0, 1,1,32'hF0,2));
        vecs.push_back(mk(1,1,0,1,32'hF3,0, 1,1,32'hF0,3));
        vecs.push_back(mk(1,1,1,0,32'h0 ,0, 0,1,32'hF0,4)); // flush from full
        vecs.push_back(mk(1,1,0,0,32'h0 ,0, 1,0,32'h0 ,0));

        // Power-up: hold reset across two edges so every flop is defined.
        drive(0, 0, 0, 0, '0, 0);
        repeat (2) @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].flush,
                  vecs[i].in_vld, vecs[i].in_data, vecs[i].out_rdy);
            sample($sformatf("v%0d", i), vecs[i].exp_in_rdy,
                   vecs[i].exp_out_vld, vecs[i].exp_data, vecs[i].exp_occ);
        end

        // First word into an empty FIFO with everything ready.
        drive(1, 1, 0, 1, 32'hC3, 1);
`ifdef FLOW_CONTROL_RX_BYPASS_EN
        sample("byp_same_cycle", 1, 1, 32'hC3, 0);
        drive(1, 1, 0, 0, '0, 1);
        sample("byp_after", 1, 0, 32'h0, 0);
`else
        sample("nobyp_same_cycle", 1, 0, 32'h0, 0);
        drive(1, 1, 0, 0, '0, 1);
        sample("nobyp_next_cycle", 1, 1, 32'hC3, 1);
`endif
        drive(1, 1, 0, 0, '0, 0);
        sample("c3_drained", 1, 0, 32'h0, 0);

        // Randomized phase against a queue model: 16 cycles of continuous
        // streaming, then random stalls, enable drops and rare flushes.
        q.delete();
        m_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (i < 16) begin
                r_en = 1; r_fl = 0; r_iv = 1; r_or = 1;
            end else begin
                r_en = ($urandom_range(0, 7) != 0);
                r_fl = ($urandom_range(0, 31) == 0);
                r_iv = $urandom_range(0, 1);
                r_or = $urandom_range(0, 1);
            end
            r_d = $urandom;
            drive(1, r_en, r_fl, r_iv, r_d, r_or);

            x_byp  = BYP && (q.size() == 0) && r_en && r_iv && m_rdy && r_or && !r_fl;
            x_vld  = (r_en && q.size() != 0) || x_byp;
            x_data = x_byp ? r_d : ((q.size() != 0) ? q[0] : 32'h0);

            @(negedge clk);
            check($sformatf("r%0d_in_rdy", i), 32'(in_rdy), 32'(m_rdy));
            check($sformatf("r%0d_out_vld", i), 32'(out_vld), 32'(x_vld));
            check($sformatf("r%0d_occ", i), 32'(occupancy), 32'(q.size()));
            check($sformatf("r%0d_occ_bound", i), 32'(occupancy <= 3'd4), 32'd1);
            if (x_vld) check($sformatf("r%0d_data", i), out_data, x_data);

            // Model update for this edge.
            if (r_fl) begin
                q.delete();
                m_rdy = 1'b1;
            end else begin
                x_pop  = !x_byp && x_vld && r_or;
                x_push = !x_byp && r_iv && m_rdy;
                if (x_pop) void'(q.pop_front());
                if (x_push) q.push_back(r_d);
                m_rdy = (q.size() < DEPTH);
            end
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
